// File: rtl/sar_seq_avg.sv
// sar_seq_avg: paces periodic SAR conversions and averages 2^Log2N results,
// handing the mean downstream over a valid/ready handshake.
module sar_seq_avg #(
   parameter int Width   = 6,
   parameter int Log2N   = 2,
   parameter int PeriodW = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic [PeriodW-1:0] period_i,
   input  logic               eoc_i,
   input  logic [Width-1:0]   result_i,
   input  logic               ready_i,
   output logic               start_o,
   output logic [Width-1:0]   avg_o,
   output logic               valid_o,
   output logic               err_o
);
   localparam int AccW   = Width + Log2N;
   localparam int TmoMax = 2 * Width + 7;
   localparam int TmoW   = $clog2(TmoMax + 1);
   typedef enum logic [2:0] {IDLE, WAIT, START, CONV, OUT} state_t;
   state_t state, state_d;
   logic [PeriodW-1:0] cnt, cnt_d;
   logic [AccW-1:0] acc, acc_d, acc_inc;
   logic [Log2N:0] n, n_d, n_inc;
   logic [TmoW-1:0] tmo, tmo_d;
   logic eoc_q, err_d, rise;
   assign rise    = eoc_i & ~eoc_q;
   assign acc_inc = acc + AccW'(result_i);
   assign n_inc   = n + 1'b1;
   assign start_o = state == START;
   assign valid_o = state == OUT;
   assign avg_o   = acc[AccW-1:Log2N];
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      acc_d   = acc;
      n_d     = n;
      tmo_d   = tmo;
      err_d   = err_o;
      case (state)
         IDLE: if (enable_i && eoc_i) begin
            cnt_d   = period_i;
            state_d = WAIT;
         end
         WAIT: if (!enable_i) begin
            acc_d   = '0;
            n_d     = '0;
            state_d = IDLE;
         end else if (cnt == '0) state_d = START;
         else cnt_d = cnt - 1'b1;
         START: begin
            tmo_d   = '0;
            state_d = CONV;
         end
         CONV: if (rise) begin
            acc_d = acc_inc;
            n_d   = n_inc;
            // n_inc's MSB marks the 2^Log2N-th sample
            if (n_inc[Log2N]) state_d = OUT;
            else if (enable_i) begin
               cnt_d   = period_i;
               state_d = WAIT;
            end else begin
               acc_d   = '0;
               n_d     = '0;
               state_d = IDLE;
            end
         end else if (tmo == TmoW'(TmoMax)) begin
            err_d   = 1'b1;
            acc_d   = '0;
            n_d     = '0;
            state_d = IDLE;
         end else tmo_d = tmo + 1'b1;
         OUT: if (ready_i) begin
            acc_d   = '0;
            n_d     = '0;
            cnt_d   = period_i;
            state_d = enable_i ? WAIT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         n     <= '0;
         tmo   <= '0;
         err_o <= 1'b0;
         eoc_q <= 1'b1;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         acc   <= acc_d;
         n     <= n_d;
         tmo   <= tmo_d;
         err_o <= err_d;
         eoc_q <= eoc_i;
      end
   end
endmodule

// File: tb/tb_sar_seq_avg.sv
// tb_sar_seq_avg: randomized checks of the averaging sequencer against a
// behavioural SAR model and arithmetic expectations.
module tb_sar_seq_avg;
   localparam int W = 6;
   localparam int PW = 8;
   logic clk_i = 1'b0, rst_i = 1'b0, enable_i = 1'b0, eoc_i = 1'b1, ready_i = 1'b1;
   logic [PW-1:0] period_i = '0;
   logic [W-1:0] result_i = '0;
   logic start_o, valid_o, err_o;
   logic [W-1:0] avg_o;
   int n_chk = 0, n_fail = 0, cyc = 0;
   int starts[$];
   int valid_cnt = 0, overlap = 0;
   logic [W-1:0] res_tab[64];
   int sar_idx = 0, sar_cnt = 0, sar_lat = 3;
   bit sar_hang = 1'b0;
   logic [W-1:0] sar_res = '0;

   sar_seq_avg #(.Width(W), .Log2N(2), .PeriodW(PW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .period_i(period_i),
      .eoc_i(eoc_i), .result_i(result_i), .ready_i(ready_i), .start_o(start_o),
      .avg_o(avg_o), .valid_o(valid_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // SAR converter: eoc drops after a start and rises sar_lat cycles later with the next table entry
   always @(posedge clk_i) begin
      if (start_o) begin
         eoc_i   <= 1'b0;
         sar_cnt <= sar_lat;
         sar_res <= res_tab[sar_idx % 64];
         sar_idx <= sar_idx + 1;
      end else if (!eoc_i && !sar_hang) begin
         if (sar_cnt <= 1) begin
            eoc_i    <= 1'b1;
            result_i <= sar_res;
         end else sar_cnt <= sar_cnt - 1;
      end
   end

   always @(negedge clk_i) begin
      if (start_o) starts.push_back(cyc);
      if (valid_o) valid_cnt++;
      if (start_o && valid_o) overlap++;
   end

   task automatic reset_dut();
      rst_i = 1'b0;
      enable_i = 1'b0;
      ready_i = 1'b1;
      sar_hang = 1'b0;
      repeat (2) @(negedge clk_i);
      for (int i = 0; i < 50 && !eoc_i; i++) @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_i);
         ok = valid_o;
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_i);
         ok = start_o;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      n_chk++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start_o); end
      n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      n_chk++; if (avg_o !== '0) begin n_fail++; $display("FAIL reset_avg: got %0d expected 0", avg_o); end
      n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
      rst_i = 1'b1;
      repeat (10) begin
         @(negedge clk_i);
         n_chk++; if (start_o !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: got %b expected 0", start_o); end
      end
   endtask

   task automatic test_basic();
      int b, s0, gap;
      bit ok;
      reset_dut();
      sar_lat = $urandom_range(1, 6);
      period_i = 8'd3;
      ready_i = 1'b0;
      b = sar_idx;
      for (int k = 0; k < 4; k++) res_tab[(b + k) % 64] = W'(10 + k);
      s0 = starts.size();
      enable_i = 1'b1;
      wait_valid(400, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_valid: got no valid_o expected valid within 400 cycles"); end
      n_chk++; if (avg_o !== 6'd11) begin n_fail++; $display("FAIL basic_avg: got %0d expected 11", avg_o); end
      n_chk++; if (starts.size() - s0 != 4) begin n_fail++; $display("FAIL basic_starts: got %0d expected 4", starts.size() - s0); end
      gap = 1 + (sar_lat + 1) + (3 + 1);
      for (int k = 1; k < starts.size() - s0; k++) begin
         n_chk++;
         if (starts[s0 + k] - starts[s0 + k - 1] != gap) begin
            n_fail++; $display("FAIL basic_gap: got %0d expected %0d", starts[s0 + k] - starts[s0 + k - 1], gap);
         end
      end
   endtask

   task automatic test_backpressure();
      int t;
      bit ok;
      repeat (20) begin
         @(negedge clk_i);
         n_chk++; if (valid_o !== 1'b1 || avg_o !== 6'd11 || start_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got valid=%b avg=%0d start=%b expected 1/11/0", valid_o, avg_o, start_o);
         end
      end
      ready_i = 1'b1;
      t = cyc;
      @(negedge clk_i);
      n_chk++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", valid_o); end
      wait_start(100, ok);
      n_chk++; if (!ok || cyc != t + 3 + 2) begin
         n_fail++; $display("FAIL bp_restart: got cycle %0d expected %0d", cyc - t, 5);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      reset_dut();
      sar_lat = 3;
      sar_hang = 1'b1;
      period_i = PW'($urandom_range(0, 5));
      enable_i = 1'b1;
      wait_start(100, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL to_start: got no start_o expected one"); end
      repeat (20) @(negedge clk_i);
      n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b expected 0", err_o); end
      @(negedge clk_i);
      n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", err_o); end
      repeat (10) begin
         @(negedge clk_i);
         n_chk++; if (start_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL to_idle: got start=%b valid=%b expected 0/0", start_o, valid_o);
         end
      end
      sar_hang = 1'b0;
      wait_start(100, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL to_resume: got no start_o expected one"); end
      n_chk++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", err_o); end
      rst_i = 1'b0;
      @(negedge clk_i);
      n_chk++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", err_o); end
   endtask

   task automatic test_enable_drop();
      int b, s0, v0, sum;
      bit ok;
      logic [W-1:0] r;
      reset_dut();
      sar_lat = $urandom_range(1, 6);
      period_i = PW'($urandom_range(0, 4));
      b = sar_idx;
      for (int k = 0; k < 3; k++) res_tab[(b + k) % 64] = W'($urandom_range(0, 63));
      s0 = starts.size();
      v0 = valid_cnt;
      enable_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_start(200, ok);
         n_chk++; if (!ok) begin n_fail++; $display("FAIL drop_start%0d: got none expected start_o", k); end
      end
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (60) @(negedge clk_i);
      n_chk++; if (starts.size() - s0 != 3) begin n_fail++; $display("FAIL drop_starts: got %0d expected 3", starts.size() - s0); end
      n_chk++; if (valid_cnt != v0) begin n_fail++; $display("FAIL drop_valid: got %0d valid cycles expected 0", valid_cnt - v0); end
      n_chk++; if (sar_idx - b != 3) begin n_fail++; $display("FAIL drop_completed: got %0d conversions expected 3", sar_idx - b); end
      b = sar_idx;
      sum = 0;
      for (int k = 0; k < 4; k++) begin
         r = W'($urandom_range(0, 63));
         res_tab[(b + k) % 64] = r;
         sum += int'(r);
      end
      enable_i = 1'b1;
      wait_valid(400, ok);
      n_chk++; if (!ok || avg_o !== W'(sum / 4)) begin
         n_fail++; $display("FAIL drop_fresh_avg: got %0d expected %0d", avg_o, sum / 4);
      end
   endtask

   task automatic test_reset_mid();
      int b;
      bit ok;
      reset_dut();
      sar_lat = $urandom_range(2, 6);
      period_i = PW'($urandom_range(0, 4));
      b = sar_idx;
      res_tab[b % 64] = W'($urandom_range(4, 63));
      res_tab[(b + 1) % 64] = W'($urandom_range(0, 63));
      for (int k = 2; k < 6; k++) res_tab[(b + k) % 64] = 6'd63;
      enable_i = 1'b1;
      wait_start(200, ok);
      wait_start(200, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rm_start: got none expected start_o"); end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      n_chk++; if (start_o !== 1'b0 || valid_o !== 1'b0 || avg_o !== '0 || err_o !== 1'b0) begin
         n_fail++; $display("FAIL rm_outputs: got start=%b valid=%b avg=%0d err=%b expected all 0", start_o, valid_o, avg_o, err_o);
      end
      rst_i = 1'b1;
      wait_valid(600, ok);
      n_chk++; if (!ok || avg_o !== 6'd63) begin n_fail++; $display("FAIL rm_avg: got %0d expected 63", avg_o); end
   endtask

   task automatic test_back_to_back();
      int b, s0, sum;
      int sums[3];
      bit ok;
      logic [W-1:0] r;
      reset_dut();
      sar_lat = $urandom_range(1, 6);
      period_i = '0;
      b = sar_idx;
      for (int k = 0; k < 12; k++) begin
         r = W'($urandom_range(0, 63));
         res_tab[(b + k) % 64] = r;
         if (k % 4 == 0) sums[k / 4] = 0;
         sums[k / 4] += int'(r);
      end
      s0 = starts.size();
      enable_i = 1'b1;
      for (int g = 0; g < 3; g++) begin
         wait_valid(400, ok);
         sum = sums[g];
         n_chk++; if (!ok || avg_o !== W'(sum / 4)) begin
            n_fail++; $display("FAIL b2b_avg%0d: got %0d expected %0d", g, avg_o, sum / 4);
         end
      end
      enable_i = 1'b0;
      n_chk++; if (starts.size() - s0 < 12) begin
         n_fail++; $display("FAIL b2b_starts: got %0d expected at least 12", starts.size() - s0);
      end else begin
         for (int g = 0; g < 3; g++)
            for (int k = 1; k < 4; k++) begin
               n_chk++;
               if (starts[s0 + 4 * g + k] - starts[s0 + 4 * g + k - 1] != (sar_lat + 1) + 2) begin
                  n_fail++; $display("FAIL b2b_gap: got %0d expected %0d",
                     starts[s0 + 4 * g + k] - starts[s0 + 4 * g + k - 1], sar_lat + 3);
               end
            end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_enable_drop();
      test_reset_mid();
      test_back_to_back();
      n_chk++; if (overlap != 0) begin n_fail++; $display("FAIL start_during_valid: got %0d cycles expected 0", overlap); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
